// File: rtl/line_page_wr_ctrl_pkg.sv
// Shared types, default geometry and helpers for the line page write controller.
package line_page_wr_ctrl_pkg;
    localparam int C_DATA_W_DEF   = 10;
    localparam int C_ADDR_W_DEF   = 9;
    localparam int C_PAGE_W_DEF   = 2;
    localparam int C_LINE_LEN_DEF = 250;
    localparam int NP             = 1 << C_PAGE_W_DEF;
    localparam int MAX_PIX        = 1 << C_ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/line_page_wr_ctrl_if.sv
// Pixel-stream / DPRAM / status bundle of line_page_wr_ctrl; master is the controller side.
// ERR_LINE_CNT exists only when LINE_WR_ERR_DROP_EN is defined.
interface line_page_wr_ctrl_if #(
    parameter int C_DATA_W = 10,
    parameter int C_ADDR_W = 9,
    parameter int C_PAGE_W = 2
);
    logic                         FRAME_SYNC;
    logic                         PULSE;
    logic [C_DATA_W-1:0]          DIN;
    logic                         PIXEL_ERROR;
    logic                         LINE_SYNC;
    logic                         RD_RELEASE;
    logic [C_PAGE_W+C_ADDR_W-1:0] DPRAM_WR_ADDR;
    logic [C_DATA_W-1:0]          DPRAM_WR_DATA;
    logic                         DPRAM_WE;
    logic                         LINE_FINISHED;
    logic [C_PAGE_W-1:0]          LINE_PAGE;
    logic [C_ADDR_W:0]            LINE_LEN;
    logic                         LINE_ERR;
    logic [C_PAGE_W:0]            PAGES_USED;
    logic [15:0]                  LINE_COUNT;
    logic                         OVERFLOW;
`ifdef LINE_WR_ERR_DROP_EN
    logic [15:0]                  ERR_LINE_CNT;
`endif

    modport master (
        input  FRAME_SYNC, PULSE, DIN, PIXEL_ERROR, LINE_SYNC, RD_RELEASE,
        output DPRAM_WR_ADDR, DPRAM_WR_DATA, DPRAM_WE, LINE_FINISHED, LINE_PAGE,
               LINE_LEN, LINE_ERR, PAGES_USED, LINE_COUNT, OVERFLOW
`ifdef LINE_WR_ERR_DROP_EN
        , output ERR_LINE_CNT
`endif
    );

    modport slave (
        output FRAME_SYNC, PULSE, DIN, PIXEL_ERROR, LINE_SYNC, RD_RELEASE,
        input  DPRAM_WR_ADDR, DPRAM_WR_DATA, DPRAM_WE, LINE_FINISHED, LINE_PAGE,
               LINE_LEN, LINE_ERR, PAGES_USED, LINE_COUNT, OVERFLOW
`ifdef LINE_WR_ERR_DROP_EN
        , input ERR_LINE_CNT
`endif
    );
endinterface

// File: rtl/line_page_wr_ctrl_page_ring_ctrl.sv
// Page ring bookkeeping: write page pointer, committed-page occupancy with
// commit/release arbitration, and the full flag that gates new lines.
module line_page_wr_ctrl_page_ring_ctrl
    import line_page_wr_ctrl_pkg::*;
#(
    parameter int C_PAGE_W = C_PAGE_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                commit,
    input  logic                rel,
    output logic [C_PAGE_W-1:0] wr_page,
    output logic [C_PAGE_W:0]   pages_used,
    output logic                full,
    output logic                will_fill
);
    localparam int UW = clog2(1 << C_PAGE_W) + 1;
    localparam logic [UW-1:0]       USED_MAX  = UW'(1 << C_PAGE_W);
    localparam logic [UW-1:0]       USED_LAST = UW'((1 << C_PAGE_W) - 1);
    localparam logic [UW-1:0]       USED_ONE  = UW'(1);
    localparam logic [C_PAGE_W-1:0] PAGE_ONE  = C_PAGE_W'(1);

    logic rel_eff;

    // A release with nothing committed is meaningless and dropped here.
    assign rel_eff   = rel && (pages_used != '0);
    assign full      = (pages_used == USED_MAX);
    assign will_fill = commit && !rel_eff && (pages_used == USED_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_page    <= '0;
            pages_used <= '0;
        end else if (clear) begin
            wr_page    <= '0;
            pages_used <= '0;
        end else begin
            if (commit)
                wr_page <= wr_page + PAGE_ONE;
            if (commit && !rel_eff)
                pages_used <= pages_used + USED_ONE;
            else if (!commit && rel_eff)
                pages_used <= pages_used - USED_ONE;
        end
    end
endmodule

// File: rtl/line_page_wr_ctrl.sv
// Line page write controller: writes deserialized lines into a ring of 2^C_PAGE_W DPRAM pages,
// validates each line and drops lines when no page is free. Optional macro LINE_WR_ERR_DROP_EN.
module line_page_wr_ctrl
    import line_page_wr_ctrl_pkg::*;
#(
    parameter int C_DATA_W   = C_DATA_W_DEF,
    parameter int C_ADDR_W   = clog2(MAX_PIX),
    parameter int C_PAGE_W   = clog2(NP),
    parameter int C_LINE_LEN = C_LINE_LEN_DEF
) (
    input  logic                CLOCK,
    input  logic                RESET,
    line_page_wr_ctrl_if.master bus
);
    localparam int CW = C_ADDR_W + 1;
    localparam logic [CW-1:0] PIX_LIMIT = CW'(1 << C_ADDR_W);
    localparam logic [CW-1:0] LEN_OK    = CW'(C_LINE_LEN);

    wr_state_t           state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt, cnt_eff;
    logic                err_flag, err_nxt, err_eff;
    logic                trunc_flag, trunc_nxt, trunc_eff;
    logic                active, wr_en, line_close, line_bad, commit, rel, will_fill, full;
    logic [C_PAGE_W-1:0] wr_page;
    logic [C_PAGE_W:0]   pages_used;

    logic                         we_p1, fin_p1, lerr_p1, ovf_p1;
    logic [C_PAGE_W+C_ADDR_W-1:0] addr_p1;
    logic [C_DATA_W-1:0]          data_p1;
    logic [C_PAGE_W-1:0]          page_p1;
    logic [CW-1:0]                len_p1;
    logic [15:0]                  line_cnt_p1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // FRAME_SYNC outranks everything else in the same cycle, so it masks all line activity.
    assign active     = (state == WRITE) && !bus.FRAME_SYNC;
    assign wr_en      = active && bus.PULSE && (cnt != PIX_LIMIT);
    assign cnt_eff    = cnt + CW'(wr_en);
    assign err_eff    = err_flag | (active & bus.PULSE & bus.PIXEL_ERROR);
    assign trunc_eff  = trunc_flag | (active & bus.PULSE & (cnt == PIX_LIMIT));
    assign line_close = active && bus.LINE_SYNC && (cnt_eff != '0);
    assign line_bad   = err_eff | trunc_eff | (cnt_eff != LEN_OK);
`ifdef LINE_WR_ERR_DROP_EN
    assign commit     = line_close && !err_eff;
`else
    assign commit     = line_close;
`endif
    assign rel        = bus.RD_RELEASE && (state != IDLE);

    line_page_wr_ctrl_page_ring_ctrl #(
        .C_PAGE_W (C_PAGE_W)
    ) u_page_ring_ctrl (
        .clk        (CLOCK),
        .rst_n      (RESET),
        .clear      (bus.FRAME_SYNC),
        .commit     (commit),
        .rel        (rel),
        .wr_page    (wr_page),
        .pages_used (pages_used),
        .full       (full),
        .will_fill  (will_fill)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_flag;
        trunc_nxt = trunc_flag;
        if (bus.FRAME_SYNC) begin
            state_nxt = WRITE;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            trunc_nxt = 1'b0;
        end else begin
            case (state)
                WRITE: begin
                    if (line_close) begin
                        cnt_nxt   = '0;
                        err_nxt   = 1'b0;
                        trunc_nxt = 1'b0;
                        if (will_fill)
                            state_nxt = DROP;
                    end else begin
                        cnt_nxt   = cnt_eff;
                        err_nxt   = err_eff;
                        trunc_nxt = trunc_eff;
                    end
                end
                // Only a line boundary may end a drop, never a release mid-line.
                DROP: if (bus.LINE_SYNC && !full) state_nxt = WRITE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            err_flag   <= 1'b0;
            trunc_flag <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            err_flag   <= err_nxt;
            trunc_flag <= trunc_nxt;
        end
    end

    // ---- stage p1: DPRAM write port and line report ----
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            we_p1       <= 1'b0;
            addr_p1     <= '0;
            data_p1     <= '0;
            fin_p1      <= 1'b0;
            page_p1     <= '0;
            len_p1      <= '0;
            lerr_p1     <= 1'b0;
            line_cnt_p1 <= '0;
            ovf_p1      <= 1'b0;
        end else begin
            we_p1  <= wr_en;
            fin_p1 <= commit;
            if (wr_en) begin
                addr_p1 <= {wr_page, cnt[C_ADDR_W-1:0]};
                data_p1 <= bus.DIN;
            end
            if (commit) begin
                page_p1 <= wr_page;
                len_p1  <= cnt_eff;
                lerr_p1 <= line_bad;
            end
            if (bus.FRAME_SYNC)
                line_cnt_p1 <= '0;
            else if (commit)
                line_cnt_p1 <= sat_inc16(line_cnt_p1);
            if ((state == DROP) && bus.PULSE && !bus.FRAME_SYNC)
                ovf_p1 <= 1'b1;
        end
    end

`ifdef LINE_WR_ERR_DROP_EN
    logic [15:0] err_cnt_p1;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)
            err_cnt_p1 <= '0;
        else if (bus.FRAME_SYNC)
            err_cnt_p1 <= '0;
        else if (line_close && err_eff)
            err_cnt_p1 <= sat_inc16(err_cnt_p1);
    end

    assign bus.ERR_LINE_CNT = err_cnt_p1;
`endif

    assign bus.DPRAM_WE      = we_p1;
    assign bus.DPRAM_WR_ADDR = addr_p1;
    assign bus.DPRAM_WR_DATA = data_p1;
    assign bus.LINE_FINISHED = fin_p1;
    assign bus.LINE_PAGE     = page_p1;
    assign bus.LINE_LEN      = len_p1;
    assign bus.LINE_ERR      = lerr_p1;
    assign bus.PAGES_USED    = pages_used;
    assign bus.LINE_COUNT    = line_cnt_p1;
    assign bus.OVERFLOW      = ovf_p1;
endmodule
